// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: frame FSM encoding, frame length
// and the bit layout of the data/status registers.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    localparam int COUNT_W      = 9;
    localparam int BIT_NOT_EMPTY = 8;
    localparam int BIT_OVERFLOW  = 9;
    localparam int BIT_FRAME_ERR = 10;
    localparam int BIT_FULL      = 11;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: line synchronisers, falling-edge detect, frame FSM and
// inter-bit timeout. Emits one-cycle byte_valid or frame_err pulses.
//
// state    | meaning
// ST_IDLE  | waiting for a start bit (0) on a PS2_clk falling edge
// ST_SHIFT | collecting 8 data bits, parity and stop; timeout armed
// ST_CHECK | one cycle: verify odd parity and stop bit, then report
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       PS2_clk,
    input  logic       PS2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 2);

    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall;

    rx_state_t state, next_state;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] timer;
    logic          start_en, shift_en;

    always_ff @(posedge system_clk) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= PS2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= PS2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge system_clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        start_en   = 1'b0;
        shift_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall && !dat_s2) begin
                    start_en   = 1'b1;
                    next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) next_state = ST_CHECK;
                end else if (timer == '0) begin
                    frame_err  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // shreg[8:0] = data + parity, shreg[9] = stop
                if ((^shreg[8:0]) && shreg[9]) byte_valid = 1'b1;
                else                           frame_err  = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign rx_byte = shreg[7:0];

    always_ff @(posedge system_clk) begin
        if (reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            timer   <= '0;
        end else if (start_en) begin
            bit_cnt <= '0;
            timer   <= TO_LOAD;
        end else if (shift_en) begin
            shreg   <= {dat_s2, shreg[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
            timer   <= TO_LOAD;
        end else if (state == ST_SHIFT && timer != '0) begin
            timer   <= timer - 1'b1;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver with scan-code FIFO and a two-register read map
// (data/pop and status with sticky overflow / frame error flags).
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 14,
    parameter int                    DATA_WIDTH     = 64,
    parameter int                    FIFO_DEPTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] DATA_ADDR      = 14'h3fff,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR    = 14'h3ffe,
    parameter int                    TIMEOUT_CYCLES = 5000
) (
    input  logic                  system_clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  PS2_data,
    input  logic                  PS2_clk,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       rx_err;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .system_clk(system_clk),
        .reset     (reset),
        .PS2_clk   (PS2_clk),
        .PS2_data  (PS2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (rx_err)
    );

    logic [7:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0] count;
    logic           overflow, err_flag;
    logic           read_prev, read_rise;
    logic           not_empty, full;
    logic           do_push, do_pop, stat_clr, ovf_set;

    assign not_empty = (count != '0);
    assign full      = (count == DEPTH_C);
    assign read_rise = read & ~read_prev;
    assign do_pop    = read_rise && (address == DATA_ADDR) && not_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign do_push   = byte_valid && (!full || do_pop);
    assign ovf_set   = byte_valid && full && !do_pop;
    assign stat_clr  = read_rise && (address == STATUS_ADDR);

    always_ff @(posedge system_clk) begin
        if (do_push) mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            err_flag  <= 1'b0;
            read_prev <= 1'b0;
        end else begin
            read_prev <= read;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_set)       overflow <= 1'b1;
            else if (stat_clr) overflow <= 1'b0;
            if (rx_err)        err_flag <= 1'b1;
            else if (stat_clr) err_flag <= 1'b0;
        end
    end

    always_comb begin
        data = '0;
        if (address == DATA_ADDR) begin
            if (not_empty) data[7:0] = mem[rd_ptr];
            data[BIT_NOT_EMPTY] = not_empty;
        end else if (address == STATUS_ADDR) begin
            data[COUNT_W-1:0]   = COUNT_W'(count);
            data[BIT_OVERFLOW]  = overflow;
            data[BIT_FRAME_ERR] = err_flag;
            data[BIT_FULL]      = full;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: PS/2 frames driven bit by bit, register
// reads checked against hand-computed values.
module tb_ps2_rx_fifo;

    localparam int          TO    = 200;
    localparam logic [13:0] A_DAT = 14'h3fff;
    localparam logic [13:0] A_ST  = 14'h3ffe;
    localparam logic [13:0] A_OTH = 14'h0123;

    logic        system_clk = 1'b0;
    logic        reset      = 1'b1;
    logic [13:0] address    = '0;
    logic        PS2_data   = 1'b1;
    logic        PS2_clk    = 1'b1;
    logic        read       = 1'b0;
    logic [63:0] data;

    int total = 0;
    int bad   = 0;

    ps2_rx_fifo #(
        .ADDR_WIDTH    (14),
        .DATA_WIDTH    (64),
        .FIFO_DEPTH    (4),
        .DATA_ADDR     (A_DAT),
        .STATUS_ADDR   (A_ST),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .system_clk(system_clk),
        .reset     (reset),
        .address   (address),
        .PS2_data  (PS2_data),
        .PS2_clk   (PS2_clk),
        .read      (read),
        .data      (data)
    );

    always #5 system_clk = ~system_clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge system_clk);
    endtask

    task automatic chk(input string tag, input logic [13:0] a, input logic [63:0] exp);
        address = a;
        #1;
        total++;
        assert (data === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, data, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        PS2_data = v;
        cyc(10);
        PS2_clk = 1'b0;
        cyc(10);
        PS2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ bad_par);
        send_bit(1'b1);
        PS2_data = 1'b1;
        cyc(5);
    endtask

    task automatic strobe(input logic [13:0] a);
        address = a;
        read = 1'b1;
        cyc(1);
        read = 1'b0;
        cyc(2);
    endtask

    initial begin
        cyc(3);
        reset = 1'b0;
        cyc(2);
        chk("rst_data",   A_DAT, 64'h0);
        chk("rst_status", A_ST,  64'h0);
        chk("rst_other",  A_OTH, 64'h0);

        // good frame 0x1C
        send_frame(8'h1C, 1'b0);
        chk("f1c_data",   A_DAT, 64'h11C);
        chk("f1c_status", A_ST,  64'h001);
        chk("f1c_other",  A_OTH, 64'h0);
        strobe(A_DAT);
        chk("f1c_popped", A_DAT, 64'h0);

        // bad parity
        send_frame(8'h1C, 1'b1);
        chk("par_status", A_ST,  64'h400);
        chk("par_data",   A_DAT, 64'h0);
        strobe(A_ST);
        chk("par_clear",  A_ST,  64'h0);

        // overflow with depth 4
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0);
        chk("ovf_status", A_ST,  64'hA04);
        chk("ovf_head",   A_DAT, 64'h101);
        chk("pop1", A_DAT, 64'h101); strobe(A_DAT);
        chk("pop2", A_DAT, 64'h102); strobe(A_DAT);
        chk("pop3", A_DAT, 64'h103); strobe(A_DAT);
        chk("pop4", A_DAT, 64'h104); strobe(A_DAT);
        chk("ovf_empty",  A_DAT, 64'h0);
        strobe(A_DAT);
        chk("pop_empty_status", A_ST, 64'h200);
        strobe(A_ST);
        chk("ovf_clear",  A_ST,  64'h0);

        // read held high pops once
        send_frame(8'hAA, 1'b0);
        send_frame(8'h55, 1'b0);
        chk("hold_pre",   A_ST,  64'h002);
        address = A_DAT;
        read = 1'b1;
        cyc(10);
        read = 1'b0;
        cyc(2);
        chk("hold_status", A_ST,  64'h001);
        chk("hold_head",   A_DAT, 64'h155);
        strobe(A_DAT);
        chk("hold_empty",  A_ST,  64'h0);

        // timeout after 4 bits
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        PS2_data = 1'b1;
        cyc(TO + 20);
        chk("to_status",  A_ST,  64'h400);
        chk("to_data",    A_DAT, 64'h0);
        strobe(A_ST);
        send_frame(8'hF0, 1'b0);
        chk("to_next",    A_DAT, 64'h1F0);
        chk("to_next_st", A_ST,  64'h001);
        strobe(A_DAT);

        // reset mid-frame after bit 5
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        PS2_data = 1'b1;
        cyc(3);
        chk("mid_rst_status", A_ST, 64'h0);
        send_frame(8'h29, 1'b0);
        chk("mid_status", A_ST,  64'h001);
        chk("mid_head",   A_DAT, 64'h129);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter ADDR_WIDTH, 14, width of address.
REQ-002 Parameter DATA_WIDTH, 64, width of data; SHALL be >= 16.
REQ-003 Parameter FIFO_DEPTH, 8, scan-code entries; SHALL be a power of two, 2..256.
REQ-004 Parameter DATA_ADDR, 14'h3fff, address of the data/pop register.
REQ-005 Parameter STATUS_ADDR, 14'h3ffe, address of the status register.
REQ-006 Parameter TIMEOUT_CYCLES, 5000, system_clk cycles without a PS2_clk falling edge before a partial frame is aborted.
REQ-007 system_clk  in  1  sole clock; all state on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 address  in  ADDR_WIDTH  register select.
REQ-010 PS2_data  in  1  asynchronous PS/2 data line.
REQ-011 PS2_clk  in  1  asynchronous PS/2 clock line.
REQ-012 read  in  1  read strobe; pops on its rising edge when address==DATA_ADDR.
REQ-013 data  out  DATA_WIDTH  read data, combinational from address and current registers.

Function
REQ-014 PS2_clk and PS2_data SHALL each pass through a 2-flop synchroniser; a PS2_clk falling edge is detected as synchronised-previous=1, synchronised-current=0.
REQ-015 Frame FSM states: IDLE, SHIFT, CHECK; bits are sampled only on a detected falling edge.
REQ-016 IDLE: start bit 0 -> SHIFT, bit counter=0; start bit 1 -> stay IDLE, no flag.
REQ-017 SHIFT: capture 8 data bits LSB first, then parity, then stop; after the stop bit -> CHECK.
REQ-018 CHECK (one cycle): odd parity over data+parity AND stop==1 -> push byte; otherwise discard and set frame_err; always -> IDLE.
REQ-019 Push with FIFO full SHALL drop the new byte, keep contents, set overflow.
REQ-020 In SHIFT, TIMEOUT_CYCLES cycles without a falling edge -> IDLE, partial frame discarded, frame_err set.
REQ-021 Pushed byte SHALL be visible on data in the cycle after CHECK.
REQ-022 Pop: read synchronised-edge-detected (read=1, previous=0) with address==DATA_ADDR; holding read high pops once.
REQ-023 Pop on empty SHALL have no effect.
REQ-024 Simultaneous push and pop SHALL both occur; count unchanged; a pop on empty with simultaneous push leaves the new byte queued.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-026 address==DATA_ADDR: data[7:0]=head byte (0 if empty), data[8]=not-empty, other bits 0.
REQ-027 address==STATUS_ADDR: data[8:0]=count, data[9]=overflow, data[10]=frame_err, data[11]=full, other bits 0.
REQ-028 Read rising edge at STATUS_ADDR SHALL clear overflow and frame_err, unless set in the same cycle (set wins).
REQ-029 Any other address: data=0.

Reset
REQ-030 reset SHALL clear FSM to IDLE, bit counter, timeout counter, pointers, count, overflow, frame_err, read-edge history; synchroniser flops reset to 1.
REQ-031 Outputs after reset: data=0 at all addresses (empty, flags clear).
REQ-032 reset mid-frame SHALL discard the partial frame; the next valid start bit begins a fresh frame.

Structure
REQ-033 Shared package ps2_pkg SHALL hold the FSM state encoding, frame length (11), and status bit positions.
REQ-034 Synchroniser, edge detect, FSM and timeout SHALL live in sub-module ps2_frame_rx (outputs byte, byte_valid, frame_err pulse); FIFO and register map in ps2_rx_fifo.

Verification
REQ-035 Frame 0x1C (start 0, data LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1) -> DATA_ADDR reads 0x11C; STATUS count=1.
REQ-036 Same frame with parity 1 -> FIFO empty, STATUS data[10]=1; STATUS read -> data[10]=0.
REQ-037 FIFO_DEPTH=4, frames 0x01..0x05 -> count=4, overflow=1, head=0x01; four pops yield 0x01..0x04 then empty.
REQ-038 read held high 10 cycles at DATA_ADDR with 2 entries -> exactly one pop, count=1.
REQ-039 4 bits of a frame then PS2_clk idle TIMEOUT_CYCLES+1 cycles -> frame_err=1, empty; next full frame 0xF0 -> head 0xF0.
REQ-040 reset asserted after bit 5 of a frame, then full frame 0x29 -> only 0x29 queued, count=1, flags 0.
